// File: rtl/picorv32_mem_responder.sv
// Memory responder for the PicoRV32 native memory interface.
// Accepts one request at a time, inserts a configurable number of wait
// states, then completes with a single-cycle mem_ready pulse. The backing
// store is a small word-addressed RAM with byte-lane writes. Out-of-range
// accesses complete normally but read back a NOP and raise a sticky flag.
module picorv32_mem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int MAX_WAIT   = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic [2:0]  wait_cfg,
    output logic        busy,
    output logic        addr_err,
    output logic        proto_err,
    output logic [15:0] txn_count
);

    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [2:0]  MAX_W    = 3'(MAX_WAIT);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Word addresses above the RAM depth are out of range.
    function automatic logic in_range(input logic [31:0] addr);
        return (addr >> (DEPTH_LOG2 + 2)) == 32'd0;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [31:0] addr);
        return addr[DEPTH_LOG2+1:2];
    endfunction

    // Replace only the byte lanes selected by the strobes.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    wcnt_q, wcnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          instr_q, instr_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          aerr_q, aerr_d;
    logic          perr_q, perr_d;
    logic [15:0]   count_q, count_d;
    logic [31:0]   ram_q [DEPTH];
    logic [31:0]   ram_d [DEPTH];
    logic          enter_resp_s;
    logic [2:0]    wait_load_s;

    // Next-state, request latching, RAM update and registered output values.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        instr_d      = instr_q;
        ready_d      = 1'b0;
        rdata_d      = rdata_q;
        aerr_d       = aerr_q;
        perr_d       = perr_q;
        count_d      = count_q;
        ram_d        = ram_q;
        enter_resp_s = 1'b0;
        wait_load_s  = (wait_cfg > MAX_W) ? MAX_W : wait_cfg;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    wcnt_d  = wait_load_s;
                    if (wait_load_s == 3'd0) begin
                        state_d      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // The core must hold its request stable until mem_ready.
                if (!mem_valid || (mem_addr != addr_q) ||
                    (mem_wdata != wdata_q) || (mem_wstrb != wstrb_q)) begin
                    perr_d = 1'b1;
                end else begin
                    perr_d = perr_q;
                end
                wcnt_d = wcnt_q - 3'd1;
                if (wcnt_q == 3'd1) begin
                    state_d      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                count_d = count_q + 16'd1;
                if (in_range(addr_q)) begin
                    if (wstrb_q != 4'd0) begin
                        ram_d[word_index(addr_q)] =
                            merge_bytes(ram_q[word_index(addr_q)], wdata_q, wstrb_q);
                    end else begin
                        ram_d = ram_q;
                    end
                end else begin
                    aerr_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read data is captured on entry to RESP, before any write lands,
        // so a write returns the pre-write word.
        if (enter_resp_s) begin
            ready_d = 1'b1;
            rdata_d = in_range(addr_d) ? ram_q[word_index(addr_d)] : NOP_WORD;
        end else begin
            ready_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, request and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            instr_q <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            busy_q  <= 1'b0;
            aerr_q  <= 1'b0;
            perr_q  <= 1'b0;
            count_q <= 16'd0;
            ram_q   <= '{default: 32'd0};
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            instr_q <= instr_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            aerr_q  <= aerr_d;
            perr_q  <= perr_d;
            count_q <= count_d;
            ram_q   <= ram_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign busy      = busy_q;
    assign addr_err  = aerr_q;
    assign proto_err = perr_q;
    assign txn_count = count_q;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Randomized self-checking bench for picorv32_mem_responder against a
// transaction-level reference model (RAM array, counters, sticky flags).
module tb_picorv32_mem_responder;

    localparam int MAX_WAIT = 7;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [2:0]  wait_cfg;
    logic        busy;
    logic        addr_err;
    logic        proto_err;
    logic [15:0] txn_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl [0:63];
    logic [15:0] m_cnt;
    logic        m_aerr;
    logic        m_perr;

    picorv32_mem_responder #(.DEPTH_LOG2(6), .MAX_WAIT(MAX_WAIT)) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .wait_cfg  (wait_cfg),
        .busy      (busy),
        .addr_err  (addr_err),
        .proto_err (proto_err),
        .txn_count (txn_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mdl[i] = 32'd0;
        m_cnt  = 16'd0;
        m_aerr = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag, input logic [31:0] exp_rd);
        check({tag, "_ready_low"}, {31'd0, mem_ready}, 32'd0);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        check({tag, "_rdata_hold"}, mem_rdata, exp_rd);
        check({tag, "_txn_count"}, {16'd0, txn_count}, {16'd0, m_cnt});
        check({tag, "_addr_err"}, {31'd0, addr_err}, {31'd0, m_aerr});
        check({tag, "_proto_err"}, {31'd0, proto_err}, {31'd0, m_perr});
    endtask

    // One full transaction; glitch>0 drops mem_valid in that post-accept cycle.
    task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] wc, input int glitch);
        int          w;
        int          cyc;
        bit          seen;
        bit          inr;
        int          idx;
        logic [31:0] exp_rd;
        w      = (int'(wc) > MAX_WAIT) ? MAX_WAIT : int'(wc);
        inr    = (a >> 8) == 32'd0;
        idx    = int'(a[7:2]);
        exp_rd = inr ? mdl[idx] : 32'h0000_0013;

        @(negedge clock);
        mem_valid = 1'b1;
        mem_instr = 1'($urandom);
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        wait_cfg  = wc;
        @(posedge clock);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 20) begin
            @(negedge clock);
            cyc++;
            wait_cfg = 3'($urandom);
            if (mem_ready) begin
                seen = 1'b1;
                check({tag, "_latency"}, 32'(cyc), 32'(w + 1));
                check({tag, "_rdata"}, mem_rdata, exp_rd);
                check({tag, "_busy_resp"}, {31'd0, busy}, 32'd1);
                mem_valid = 1'b0;
            end else begin
                check({tag, "_busy_wait"}, {31'd0, busy}, 32'd1);
                mem_valid = (cyc == glitch) ? 1'b0 : 1'b1;
            end
        end
        check({tag, "_ready_seen"}, {31'd0, seen}, 32'd1);

        if (inr && s != 4'd0) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
        end
        if (!inr) m_aerr = 1'b1;
        if (glitch > 0 && glitch <= w) m_perr = 1'b1;
        m_cnt = m_cnt + 16'd1;

        @(negedge clock);
        check_idle_outputs(tag, exp_rd);
    endtask

    initial begin
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        wait_cfg  = 3'd0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_idle_outputs("reset", 32'd0);
        reset = 1'b0;

        // Zero-wait write then read back, count reaches 2.
        txn("w0_write", 32'h10, 32'hDEAD_BEEF, 4'hF, 3'd0, 0);
        txn("w0_read", 32'h10, 32'd0, 4'h0, 3'd0, 0);
        check("count_two", {16'd0, txn_count}, 32'd2);
        // Five wait states.
        txn("w5_read", 32'h10, 32'd0, 4'h0, 3'd5, 0);
        // Partial byte-lane write.
        txn("lane_write", 32'h10, 32'h1122_3344, 4'b0101, 3'd2, 0);
        txn("lane_read", 32'h10, 32'd0, 4'h0, 3'd1, 0);
        check("lane_value", mem_rdata, 32'hDE22_BE44);
        // Out-of-range read and write, aliasing index 0 stays untouched.
        txn("oor_read", 32'h100, 32'd0, 4'h0, 3'd1, 0);
        txn("oor_write", 32'h100, 32'hCAFE_F00D, 4'hF, 3'd0, 0);
        txn("alias_read", 32'h0, 32'd0, 4'h0, 3'd0, 0);
        // mem_valid dropped in the second wait cycle.
        txn("proto", 32'h20, 32'd0, 4'h0, 3'd3, 2);

        // Reset in the second wait cycle of a write aborts it.
        @(negedge clock);
        mem_valid = 1'b1;
        mem_addr  = 32'h24;
        mem_wdata = 32'h5555_AAAA;
        mem_wstrb = 4'hF;
        wait_cfg  = 3'd4;
        @(posedge clock);
        @(negedge clock);
        @(negedge clock);
        reset     = 1'b1;
        mem_valid = 1'b0;
        @(negedge clock);
        model_reset();
        check_idle_outputs("abort", 32'd0);
        reset = 1'b0;
        txn("abort_read", 32'h24, 32'd0, 4'h0, 3'd0, 0);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            logic [3:0]  s;
            int          g;
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h100;
            else                           a = {24'd0, 8'($urandom)};
            s = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
            txn("rand", a, $urandom, s, 3'($urandom), g);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/picorv32_mem_responder.md
PICORV32_MEM_RESPONDER -- requirements
Module: picorv32_mem_responder

Interface
REQ-001 Parameters SHALL be:
- DEPTH_LOG2, default 6, log2 of RAM depth in 32-bit words.
- MAX_WAIT, default 7, maximum wait states; range 0..7.
REQ-002 Ports SHALL be as follows; one clock; reset is synchronous and active-high:
- clock      in   1   sole clock, rising edge
- reset      in   1   synchronous, active-high
- mem_valid  in   1   core request valid
- mem_instr  in   1   request is instruction fetch
- mem_addr   in   32  byte address
- mem_wdata  in   32  write data
- mem_wstrb  in   4   byte write strobes; 0 = read
- mem_ready  out  1   one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- wait_cfg   in   3   wait states for next accepted request
- busy       out  1   transaction in progress
- addr_err   out  1   sticky: out-of-range access seen
- proto_err  out  1   sticky: request protocol violation seen
- txn_count  out  16  completed transactions, wraps 16'hFFFF->0

Function
REQ-003 State machine SHALL have states IDLE, WAIT, RESP.
REQ-004 IDLE: mem_valid=1 SHALL accept the request:
- latch mem_addr, mem_wdata, mem_wstrb, mem_instr;
- load wait counter W = min(wait_cfg, MAX_WAIT);
- go to RESP if W=0, else to WAIT.
REQ-005 WAIT SHALL decrement W each cycle and go to RESP in the cycle W reaches 0, so exactly W cycles are spent in WAIT.
REQ-006 Latency: request accepted at edge T SHALL raise mem_ready in cycle T+1+W, high for exactly one cycle.
REQ-007 RESP SHALL return to IDLE unconditionally; a new request SHALL NOT be accepted in the RESP cycle, only from the following IDLE cycle.
REQ-008 busy SHALL be 1 in WAIT and RESP, else 0.
REQ-009 RAM index SHALL be latched mem_addr[DEPTH_LOG2+1:2]; mem_addr[1:0] ignored.
REQ-010 An address is in range iff mem_addr[31:DEPTH_LOG2+2]=0.
REQ-011 In-range read (wstrb=0): mem_rdata SHALL equal the RAM word at the index during the mem_ready cycle.
REQ-012 In-range write: at the RESP edge, each byte lane i with wstrb[i]=1 SHALL be written from wdata[8i+7:8i], other lanes unchanged; mem_rdata SHALL show the pre-write word.
REQ-013 Out-of-range access:
- read returns 32'h0000_0013 (NOP);
- write is discarded;
- addr_err set at the RESP edge;
- transaction still completes normally.
REQ-014 While busy and mem_ready=0, proto_err SHALL be set if mem_valid=0 or mem_addr/mem_wdata/mem_wstrb differ from the latched values; the transaction SHALL still complete with latched values.
REQ-015 txn_count SHALL increment by 1 at each RESP edge, wrapping modulo 2^16.
REQ-016 wait_cfg changes during WAIT SHALL NOT affect the current transaction.
REQ-017 mem_rdata SHALL hold its last value outside RESP.

Reset
REQ-018 reset=1 at a rising edge SHALL force:
- state to IDLE;
- mem_ready, busy, addr_err, proto_err to 0;
- mem_rdata to 0, txn_count to 0;
- all RAM words to 0.
REQ-019 reset during WAIT or RESP SHALL abort the transaction: no RAM write, no mem_ready pulse, txn_count=0.
REQ-020 Only reset SHALL clear addr_err and proto_err.

Verification
REQ-021 wait_cfg=0, write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, then read 0x10 -> each mem_ready exactly 1 cycle after accept; read returns 0xDEADBEEF; txn_count=2.
REQ-022 wait_cfg=5, read 0x10 -> mem_ready in cycle T+6, single cycle, busy=1 in cycles T+1..T+6.
REQ-023 Word 0x10=0xDEADBEEF, write wstrb 4'b0101, wdata 0x11223344, then read -> 0xDE22BE44.
REQ-024 Read 0x0000_0100 (DEPTH_LOG2=6) -> rdata 0x00000013, addr_err=1; a write there leaves RAM unchanged.
REQ-025 wait_cfg=3, drop mem_valid in 2nd WAIT cycle -> proto_err=1, mem_ready still pulses at T+4.
REQ-026 Write with wait_cfg=4, reset asserted in 2nd WAIT cycle -> no mem_ready; word still 0; outputs at reset values next cycle.
